// File: rtl/gf283_pkg.sv
// Shared constants and types for GF(2^283) reduction, f(x) = x^283 + x^12 + x^7 + x^5 + 1.
package gf283_pkg;
  localparam int M      = 283;
  localparam int PROD_W = 2*M-1;
  localparam int MID_W  = M+11;
  localparam int N_TAPS = 4;
  localparam int RED_TAPS [N_TAPS] = '{12, 7, 5, 0};

  typedef logic [M-1:0] gf_elem_t;
endpackage

// File: rtl/gf283_fold.sv
// One reduction fold: lo ^ hi*(x^12 + x^7 + x^5 + 1), all terms zero-extended to OUT_W.
module gf283_fold
  import gf283_pkg::*;
#(
  parameter int LO_W  = M,
  parameter int HI_W  = M-1,
  parameter int OUT_W = MID_W
) (
  input  logic [LO_W-1:0]  i_lo,
  input  logic [HI_W-1:0]  i_hi,
  output logic [OUT_W-1:0] o_fold
);
  logic [OUT_W-1:0] w_hi_ext;

  assign w_hi_ext = OUT_W'(i_hi);

  // OUT_W is chosen by the caller so that hi<<12 never overflows.
  always_comb begin
    o_fold = OUT_W'(i_lo);
    for (int k = 0; k < N_TAPS; k++) begin
      o_fold = o_fold ^ (w_hi_ext << RED_TAPS[k]);
    end
  end
endmodule

// File: rtl/gf283_reduce_pipe.sv
// Two-stage elastic pipeline reducing a 565-bit carry-less product mod f(x).
module gf283_reduce_pipe
  import gf283_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M-1:0]      out_elem,
  output logic              busy
);
  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [MID_W-1:0] r_s1_data;
  gf_elem_t         r_s2_data;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic [MID_W-1:0] w_fold1;
  gf_elem_t         w_fold2;

  gf283_fold #(.LO_W(M), .HI_W(PROD_W-M), .OUT_W(MID_W)) u_fold1 (
    .i_lo   (in_prod[M-1:0]),
    .i_hi   (in_prod[PROD_W-1:M]),
    .o_fold (w_fold1)
  );

  // Second fold only sees an 11-bit overflow, so its result already fits in M bits.
  gf283_fold #(.LO_W(M), .HI_W(MID_W-M), .OUT_W(M)) u_fold2 (
    .i_lo   (r_s1_data[M-1:0]),
    .i_hi   (r_s1_data[MID_W-1:M]),
    .o_fold (w_fold2)
  );

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign out_elem  = r_s2_data;
  assign busy      = r_s1_valid | r_s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s2_data  <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        r_s1_data  <= w_fold1;
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        r_s2_data  <= w_fold2;
      end
    end
  end
endmodule

// File: tb/tb_gf283_reduce_pipe.sv
// Self-checking bench for gf283_reduce_pipe against a bit-serial polynomial reduction model.
module tb_gf283_reduce_pipe;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [564:0] in_prod;
  logic         out_valid;
  logic         out_ready;
  logic [282:0] out_elem;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  gf283_reduce_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_elem  (out_elem),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Long division by f(x): cancel every coefficient at or above x^283 from the top down.
  function automatic logic [282:0] ref_reduce(input logic [564:0] p);
    logic [564:0] t;
    t = p;
    for (int i = 564; i >= 283; i--) begin
      if (t[i]) begin
        t[i]          = 1'b0;
        t[i-283]      = ~t[i-283];
        t[i-283+5]    = ~t[i-283+5];
        t[i-283+7]    = ~t[i-283+7];
        t[i-283+12]   = ~t[i-283+12];
      end
    end
    return t[282:0];
  endfunction

  function automatic logic [564:0] rand_prod();
    logic [575:0] t;
    for (int i = 0; i < 18; i++) t[i*32 +: 32] = $urandom;
    return t[564:0];
  endfunction

  // Samples handshake state mid-cycle, then advances past the next rising edge.
  task automatic cycle(output bit acc, output bit emt, output logic [282:0] elem,
                       output bit rdy, output bit ov);
    @(negedge clk);
    acc  = in_valid && in_ready;
    emt  = out_valid && out_ready;
    elem = out_elem;
    rdy  = in_ready;
    ov   = out_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (out_elem !== '0) begin n_err++; $display("FAIL reset_out_elem got=%h exp=0", out_elem); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  // Single transfer through an empty pipe: checks acceptance, fill latency and value.
  task automatic test_single(input logic [564:0] p, input string name,
                             output logic [282:0] got);
    bit acc, emt, rdy, ov;
    logic [282:0] e, exp_v;
    exp_v = ref_reduce(p);
    got = 'x;
    in_valid = 1'b1; in_prod = p; out_ready = 1'b1;
    cycle(acc, emt, e, rdy, ov);
    in_valid = 1'b0; in_prod = '0;
    n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL %s_accept got=%b exp=1", name, acc); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_early_valid got=%b exp=0", name, out_valid); end
    cycle(acc, emt, e, rdy, ov);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s_latency got=%b exp=1", name, out_valid); end
    got = out_elem;
    n_cmp++; if (out_elem !== exp_v) begin n_err++; $display("FAIL %s_value got=%h exp=%h", name, out_elem, exp_v); end
    cycle(acc, emt, e, rdy, ov);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_drain got=%b exp=0", name, out_valid); end
  endtask

  task automatic test_taps();
    logic [564:0] p;
    logic [282:0] got, lit;
    p = '0; p[283] = 1'b1;
    test_single(p, "x283", got);
    lit = 283'h10A1;
    n_cmp++; if (got !== lit) begin n_err++; $display("FAIL x283_literal got=%h exp=%h", got, lit); end
    p = '0; p[564] = 1'b1;
    test_single(p, "x564", got);
    lit = '0;
    lit[281] = 1'b1; lit[22] = 1'b1; lit[12] = 1'b1; lit[10] = 1'b1;
    lit[8] = 1'b1; lit[5] = 1'b1; lit[3] = 1'b1;
    n_cmp++; if (got !== lit) begin n_err++; $display("FAIL x564_literal got=%h exp=%h", got, lit); end
  endtask

  task automatic test_passthrough();
    logic [564:0] p, r;
    logic [282:0] got;
    p = '0; p[0] = 1'b1;
    test_single(p, "one", got);
    n_cmp++; if (got !== p[282:0]) begin n_err++; $display("FAIL one_identity got=%h exp=%h", got, p[282:0]); end
    r = rand_prod();
    p = '0; p[282:0] = r[282:0];
    test_single(p, "lowdeg", got);
    n_cmp++; if (got !== p[282:0]) begin n_err++; $display("FAIL lowdeg_identity got=%h exp=%h", got, p[282:0]); end
    p = '0;
    test_single(p, "zero", got);
    n_cmp++; if (got !== '0) begin n_err++; $display("FAIL zero_identity got=%h exp=0", got); end
  endtask

  task automatic test_backpressure();
    logic [564:0] vec [4];
    bit acc, emt, rdy, ov;
    logic [282:0] e, exp_v;
    int idx = 0, got = 0, gaps = 0;
    for (int i = 0; i < 4; i++) vec[i] = rand_prod();
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (idx < 4);
      in_prod   = (idx < 4) ? vec[idx] : '0;
      cycle(acc, emt, e, rdy, ov);
      if (acc) idx++;
      if (cyc >= 2 && cyc < 5) begin
        exp_v = ref_reduce(vec[0]);
        n_cmp++; if (rdy !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, rdy); end
        n_cmp++; if (ov !== 1'b1 || e !== exp_v) begin n_err++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", cyc, ov, e, exp_v); end
      end
      if (emt) begin
        exp_v = ref_reduce(vec[got]);
        n_cmp++; if (e !== exp_v) begin n_err++; $display("FAIL bp_order idx=%0d got=%h exp=%h", got, e, exp_v); end
        got++;
      end else if (got > 0 && got < 4) begin
        gaps++;
      end
    end
    in_valid = 1'b0; in_prod = '0;
    n_cmp++; if (got != 4) begin n_err++; $display("FAIL bp_count got=%0d exp=4", got); end
    n_cmp++; if (gaps != 0) begin n_err++; $display("FAIL bp_gaps got=%0d exp=0", gaps); end
  endtask

  task automatic test_stream();
    logic [282:0] exp_q [$];
    bit acc, emt, rdy, ov;
    logic [282:0] e, exp_v;
    int sent = 0, got = 0, bad = 0, stalls = 0, first = -1, last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 1100 && got < 1000; cyc++) begin
      in_valid = (sent < 1000);
      in_prod  = (sent < 1000) ? rand_prod() : '0;
      cycle(acc, emt, e, rdy, ov);
      if (in_valid && !acc) stalls++;
      if (acc) begin exp_q.push_back(ref_reduce(in_prod)); sent++; end
      if (emt) begin
        if (first < 0) first = cyc;
        last = cyc;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL stream_spurious cyc=%0d got=%h exp=none", cyc, e);
        end else begin
          exp_v = exp_q.pop_front();
          n_cmp++; if (e !== exp_v) begin n_err++; bad++; if (bad < 5) $display("FAIL stream_value idx=%0d got=%h exp=%h", got, e, exp_v); end
        end
        got++;
      end
    end
    in_valid = 1'b0; in_prod = '0;
    n_cmp++; if (got != 1000) begin n_err++; $display("FAIL stream_count got=%0d exp=1000", got); end
    n_cmp++; if (stalls != 0) begin n_err++; $display("FAIL stream_stalls got=%0d exp=0", stalls); end
    n_cmp++; if (first != 2 || last - first + 1 != 1000) begin n_err++; $display("FAIL stream_rate first=%0d span=%0d exp=2/1000", first, last - first + 1); end
  endtask

  task automatic test_reset_mid();
    bit acc, emt, rdy, ov;
    logic [282:0] e, got;
    int stale = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_prod = rand_prod();
      cycle(acc, emt, e, rdy, ov);
    end
    in_valid = 1'b0; in_prod = '0;
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_full got=%b/%b exp=1/1", busy, out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_cmp++; if (out_elem !== '0) begin n_err++; $display("FAIL rstmid_out_elem got=%h exp=0", out_elem); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(acc, emt, e, rdy, ov);
      if (ov) stale++;
    end
    n_cmp++; if (stale != 0) begin n_err++; $display("FAIL rstmid_stale got=%0d exp=0", stale); end
    test_single(rand_prod(), "post_rst", got);
  endtask

  initial begin
    test_reset();
    test_taps();
    test_passthrough();
    test_backpressure();
    test_stream();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gf283_reduce_pipe.md
Name: gf283_reduce_pipe

Overview:
- Downstream consumer of the 283-bit Karatsuba multiplier tree. It takes the raw 565-bit carry-less product and reduces it modulo f(x) = x^283 + x^12 + x^7 + x^5 + 1 to a 283-bit field element.
- Implemented as a 2-stage elastic pipeline with valid/ready handshakes on both sides, so it can sit between the combinational multiplier and any stalled consumer, such as the point-arithmetic sequencer.

Parameters:
- M, 283, field degree; fixed by the reduction taps, and any other value is unsupported.
- PROD_W, 2*M-1 (565), input product width.
- MID_W, M+11 (294), width of the stage-1 intermediate.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_prod is valid this cycle
- in_ready  out  1  block accepts in_prod this cycle
- in_prod  in  565  unreduced product, bit i = coefficient of x^i
- out_valid  out  1  out_elem holds a reduced result
- out_ready  in  1  consumer accepts out_elem this cycle
- out_elem  out  283  product mod f(x)
- busy  out  1  any pipeline stage holds valid data

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - s1_valid, s2_valid and out_valid go to 0.
  - All data registers go to 0; out_elem reads 0.
  - busy goes to 0.
  - Reset asserted mid-operation discards all in-flight data. Nothing is emitted after reset deasserts until a new input is accepted.
- Arithmetic is GF(2): every "+" is XOR. There is no carry anywhere.
- Stage 1 (fold 1), on an accepted input:
  - L = in_prod[282:0], H = in_prod[564:283] (282 bits).
  - s1_data[293:0] = L ^ H ^ (H<<5) ^ (H<<7) ^ (H<<12), with every term zero-extended to 294 bits.
- Stage 2 (fold 2), on stage-1 advance:
  - L2 = s1_data[282:0], H2 = s1_data[293:283] (11 bits).
  - s2_data = L2 ^ H2 ^ (H2<<5) ^ (H2<<7) ^ (H2<<12). Maximum degree is 22, so no third fold is needed.
- out_elem = s2_data and out_valid = s2_valid.
- Handshake rules:
  - A transfer occurs on a clock edge where valid && ready are both 1.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is a combinational path from out_ready; there is no path from in_valid to in_ready.
  - s2_valid is loaded with s1_valid when s2_adv; s1_valid is loaded with in_valid when s1_adv.
  - Data registers load only when their stage advances. Otherwise they hold.
- Latency and throughput:
  - Latency is 2 cycles: an input accepted at edge N is presented at edge N+2.
  - Throughput is 1 result per cycle when out_ready stays high.
- Full condition: when both stages are valid and out_ready=0, in_ready=0 and both stages hold unchanged.
- Simultaneous accept and emit while full: when out_ready=1 with the pipeline full, in_ready=1 in the same cycle, and the pipe shifts with no bubble.
- out_elem and out_valid stay stable while out_valid=1 and out_ready=0 (AXI-style hold).
- In-order delivery. No drops, no duplicates.
- busy = s1_valid | s2_valid.
- An input already of degree < 283 passes through unchanged.

Decomposition:
- Shared package gf283_pkg holds:
  - constants M=283 and PROD_W=565;
  - tap offsets RED_TAPS = {12, 7, 5, 0};
  - the typedef for a 283-bit field element.
- One natural sub-module, gf283_fold. It is a combinational, parameterized function with inputs lo, hi and width parameters, and it returns lo ^ hi ^ hi<<5 ^ hi<<7 ^ hi<<12.
- gf283_fold is instantiated twice, with HI_W=282 and HI_W=11.
- The top level holds only the two pipeline registers and the handshake logic.

Test Plan:
- Input x^283 (in_prod = 1<<283), out_ready=1: out_valid rises 2 cycles after acceptance with out_elem = 0x10A1 (bits 12, 7, 5, 0).
- Input x^564 (in_prod = 1<<564): out_elem has exactly bits {281, 22, 12, 10, 8, 5, 3} set, which exercises the second fold.
- Input with degree < 283 (in_prod = 0x1, then a random 283-bit value): out_elem equals the input. Input 0 gives 0.
- Backpressure:
  - Stimulus: 4 back-to-back inputs A, B, C, D; out_ready=0 for 5 cycles, then 1.
  - Required: in_ready drops after A and B are accepted; out_elem holds red(A) stably while stalled; outputs then arrive in order red(A), red(B), red(C), red(D) with no gaps.
- Full-speed streaming: 1000 random products with in_valid=out_ready=1 continuously. Every output must match a software reference (carry-less reduce mod f) at 1 result per cycle after the 2-cycle fill.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while both stages are valid.
  - Required: next cycle out_valid=0, busy=0 and out_elem=0; no stale result appears afterwards; the first post-reset input emerges 2 cycles after acceptance.
